grp_pingpong_writer: RTL and testbench
======================================

# grp_pingpong_writer

Write side of the group double buffer. Takes the 16-bit words and `ready` strobes from the serial receiver and writes their 12-bit payloads into whichever of the two group RAMs the frame former is not reading. It holds a filled buffer until the frame former reports the end of a group, then swaps the buffers by toggling `bufSwitch`. It sits between the receiver and the two `grpBuffer` RAM write ports, and its `bufSwitch` drives the read-side RAM selection.

## Interface
- `ADDR_W`, 10, RAM address width.
- `GRP_WORDS`, 1024, words per group; legal range 2..2^ADDR_W.
- `clk`  in  1  system clock; every input is synchronous to it.
- `reset`  in  1  synchronous, active-high.
- `word`  in  16  received word. Bit 15 = start-of-group marker. Bits 14:12 are ignored. Bits 11:0 = payload.
- `ready`  in  1  one-cycle strobe marking `word` valid.
- `grpDone`  in  1  one-cycle pulse from the frame former: it has finished reading the current read buffer.
- `bufSwitch`  out  1  read buffer select (0 = m0, 1 = m1). The writer always writes buffer `!bufSwitch`.
- `wrData`  out  12  RAM write data.
- `wrAddr`  out  ADDR_W  RAM write address.
- `wrEn0`  out  1  write enable for m0.
- `wrEn1`  out  1  write enable for m1.
- `bufFull`  out  1  the write buffer holds a complete group.
- `overrun`  out  1  sticky: a word was dropped because the write buffer was full.
- `underrun`  out  1  sticky: `grpDone` arrived while the write buffer was not full.

## Operation
- FSM states: HUNT, FILL, FULL. Reset enters HUNT.
- HUNT
  - `ready` with `word[15]=1`: write the payload at address 0, set the write pointer to 1, go to FILL.
  - `ready` with `word[15]=0`: discard the word, no flag.
- FILL
  - Each `ready` writes the payload at the pointer, then the pointer increments.
  - After the write at address GRP_WORDS-1, go to FULL and set `bufFull`.
  - `ready` with `word[15]=1` in FILL: resynchronise. Write at address 0, pointer becomes 1, stay in FILL. The partial group is abandoned.
- FULL
  - `ready`: no write; set `overrun`.
  - `grpDone`: toggle `bufSwitch`, clear `bufFull`, go to HUNT.
- `grpDone` in HUNT or FILL: set `underrun`. `bufSwitch` does not change, so the reader re-reads the old group. The FSM state and pointer are unchanged.
- `grpDone` and `ready` in the same cycle while in FULL: the swap takes effect first, and the word is then handled under HUNT rules with the new `!bufSwitch` as the target. A start-of-group word is therefore written at address 0 of the newly freed buffer, and `overrun` is not set.
- Write target: `wrEn0 = wrStrobe & bufSwitch_target==0`, `wrEn1 = wrStrobe & bufSwitch_target==1`, where target = `!bufSwitch` in effect for that word. `wrEn0` and `wrEn1` are never high together.
- Pointer arithmetic: ADDR_W bits, no wrap. The pointer reaches GRP_WORDS-1 at most, then FULL is forced.
- `overrun` and `underrun` are cleared only by `reset`.

## Timing
- Reset values: `bufSwitch`=0, `wrEn0`=`wrEn1`=0, `wrData`=0, `wrAddr`=0, `bufFull`=0, `overrun`=0, `underrun`=0, state HUNT, pointer 0.
- `reset` high mid-operation: all of the above are restored on the next edge. A pending write is cancelled, with no enable in the following cycle.
- Write latency: `ready` sampled at edge N. `wrEn*`, `wrData` and `wrAddr` are registered and valid for exactly one cycle after edge N+1.
- `bufFull` rises at the same edge as the last write's enable.
- Swap latency: `grpDone` sampled at edge N. `bufSwitch` and `bufFull` update at edge N+1.
- Flag latency: `overrun` and `underrun` set at edge N+1 of the offending strobe.
- Back-to-back `ready` every cycle is supported at full rate.

## Test plan
- Fill with GRP_WORDS=8: reset, then `ready` on words 0x8001, 0x0002 … 0x0008 -> `wrEn1` pulses at addresses 0..7 with data 0x001..0x008. `bufFull`=1 one cycle after the 8th strobe. `wrEn0` is never high.
- Swap: after the fill above, pulse `grpDone` -> `bufSwitch`=1 one cycle later and `bufFull`=0. The next group 0x8AAA… writes via `wrEn0` starting at address 0.
- Hunt and resync: words 0x0123, 0x0456 in HUNT -> no enables. Then 0x8111, 0x0222, 0x8333 -> writes at addresses 0, 1, 0 with data 0x111, 0x222, 0x333, and the pointer is left at 1.
- Overrun and underrun: with the buffer FULL, send a 9th word -> no enable and `overrun`=1. After the swap, `grpDone` during FILL -> `underrun`=1 and `bufSwitch` is unchanged.
- Simultaneous events: FULL with `bufSwitch`=0. Drive `grpDone` plus `ready` with 0x8ABC in the same cycle -> next cycle `bufSwitch`=1 and `wrEn0`=1 at address 0 with data 0xABC. `overrun` stays 0.
- Reset mid-fill: after 3 writes, assert `reset` alongside a `ready` -> next cycle all outputs hold their reset values with no enable. The following 0x8005 writes address 0 of m1.

Source files
------------

// File: rtl/grp_pingpong_writer.sv
// Write side of the group double buffer: steers received 12-bit payloads
// into the RAM not being read, holds a completed group until the reader
// finishes, then swaps buffers.
module grp_pingpong_writer #(
   parameter int ADDR_W    = 10,
   parameter int GRP_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       word,
   input  logic              ready,
   input  logic              grpDone,
   output logic              bufSwitch,
   output logic [11:0]       wrData,
   output logic [ADDR_W-1:0] wrAddr,
   output logic              wrEn0,
   output logic              wrEn1,
   output logic              bufFull,
   output logic              overrun,
   output logic              underrun
);

   typedef enum logic [1:0] {HUNT, FILL, FULL} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRP_WORDS - 1);

   state_t            state;
   logic [ADDR_W-1:0] ptr;

   // A grpDone in FULL swaps first; the word of the same cycle sees the swapped view
   state_t eff_state;
   logic   eff_switch;
   logic   swap;

   // Resolve a same-cycle swap before the word is interpreted
   always_comb begin
      swap       = grpDone && (state == FULL);
      eff_state  = state;
      eff_switch = bufSwitch;
      if (swap) begin
         eff_state  = HUNT;
         eff_switch = ~bufSwitch;
      end
   end

   // Main FSM: pointer, buffer select, registered RAM write port and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HUNT;
         ptr       <= '0;
         bufSwitch <= 1'b0;
         wrData    <= '0;
         wrAddr    <= '0;
         wrEn0     <= 1'b0;
         wrEn1     <= 1'b0;
         bufFull   <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         wrEn0 <= 1'b0;
         wrEn1 <= 1'b0;

         if (swap) begin
            bufSwitch <= eff_switch;
            bufFull   <= 1'b0;
            state     <= HUNT;
         end else if (grpDone) begin
            // Reader finished early: it will re-read the old group
            underrun <= 1'b1;
         end

         if (ready) begin
            case (eff_state)
               HUNT: begin
                  if (word[15]) begin
                     wrData <= word[11:0];
                     wrAddr <= '0;
                     wrEn0  <= eff_switch;
                     wrEn1  <= ~eff_switch;
                     ptr    <= ADDR_W'(1);
                     state  <= FILL;
                  end
               end
               FILL: begin
                  wrData <= word[11:0];
                  wrEn0  <= eff_switch;
                  wrEn1  <= ~eff_switch;
                  if (word[15]) begin
                     // Start marker mid-group: abandon the partial group
                     wrAddr <= '0;
                     ptr    <= ADDR_W'(1);
                  end else begin
                     wrAddr <= ptr;
                     if (ptr == LAST_ADDR) begin
                        state   <= FULL;
                        bufFull <= 1'b1;
                     end else begin
                        ptr <= ptr + ADDR_W'(1);
                     end
                  end
               end
               FULL: begin
                  overrun <= 1'b1;
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_grp_pingpong_writer.sv
// Bench for grp_pingpong_writer: directed scenarios followed by random
// traffic, every cycle compared against a group-count reference model.
module tb_grp_pingpong_writer;

   localparam int ADDR_W = 10;
   localparam int G      = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       word;
   logic              ready;
   logic              grpDone;
   logic              bufSwitch;
   logic [11:0]       wrData;
   logic [ADDR_W-1:0] wrAddr;
   logic              wrEn0;
   logic              wrEn1;
   logic              bufFull;
   logic              overrun;
   logic              underrun;

   int n_cmp  = 0;
   int n_mism = 0;

   // Reference model: words collected in the current group (-1 = hunting, G = full)
   int         m_cnt;
   logic       m_sel;
   logic       m_full, m_ovr, m_und, m_en0, m_en1;
   logic [11:0] m_data;
   int         m_addr;

   grp_pingpong_writer #(.ADDR_W(ADDR_W), .GRP_WORDS(G)) dut (
      .clk(clk), .reset(reset), .word(word), .ready(ready), .grpDone(grpDone),
      .bufSwitch(bufSwitch), .wrData(wrData), .wrAddr(wrAddr),
      .wrEn0(wrEn0), .wrEn1(wrEn1), .bufFull(bufFull),
      .overrun(overrun), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mism++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [15:0] w, input logic gd, input logic rs);
      if (rs) begin
         m_cnt = -1; m_sel = 0; m_full = 0; m_ovr = 0; m_und = 0;
         m_en0 = 0; m_en1 = 0; m_data = 0; m_addr = 0;
         return;
      end
      m_en0 = 0; m_en1 = 0;
      if (gd) begin
         if (m_cnt == G) begin
            m_sel = ~m_sel; m_full = 0; m_cnt = -1;
         end else begin
            m_und = 1;
         end
      end
      if (r) begin
         if (m_cnt == G) begin
            m_ovr = 1;
         end else if (w[15] || m_cnt >= 0) begin
            m_addr = w[15] ? 0 : m_cnt;
            m_cnt  = m_addr + 1;
            m_data = w[11:0];
            if (m_sel) m_en0 = 1; else m_en1 = 1;
            if (m_cnt == G) m_full = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("wrEn0", 32'(wrEn0), 32'(m_en0));
      check("wrEn1", 32'(wrEn1), 32'(m_en1));
      check("bufSwitch", 32'(bufSwitch), 32'(m_sel));
      check("bufFull", 32'(bufFull), 32'(m_full));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("underrun", 32'(underrun), 32'(m_und));
      check("wrData", 32'(wrData), 32'(m_data));
      check("wrAddr", 32'(wrAddr), 32'(m_addr));
      check("enExclusive", 32'(wrEn0 & wrEn1), 32'd0);
   endtask

   task automatic step(input logic r, input logic [15:0] w, input logic gd, input logic rs);
      ready = r; word = w; grpDone = gd; reset = rs;
      @(posedge clk);
      #1;
      model_step(r, w, gd, rs);
      compare_all();
      @(negedge clk);
      ready = 0; grpDone = 0; reset = 0;
   endtask

   initial begin
      ready = 0; word = 0; grpDone = 0; reset = 1;
      m_cnt = -1; m_sel = 0; m_full = 0; m_ovr = 0; m_und = 0;
      m_en0 = 0; m_en1 = 0; m_data = 0; m_addr = 0;
      @(negedge clk);

      // Reset state
      step(0, 16'h0000, 0, 1);
      step(0, 16'h0000, 0, 0);

      // Fill one group into m1
      step(1, 16'h8001, 0, 0);
      for (int i = 2; i <= G; i++) step(1, 16'(i), 0, 0);
      check("fullAfterFill", 32'(bufFull), 32'd1);

      // Ninth word while full is dropped
      step(1, 16'h0009, 0, 0);
      check("overrunSet", 32'(overrun), 32'd1);

      // Swap, then next group goes to m0
      step(0, 16'h0000, 1, 0);
      check("switchAfterSwap", 32'(bufSwitch), 32'd1);
      step(1, 16'h8AAA, 0, 0);
      check("m0Write", 32'(wrEn0), 32'd1);
      step(1, 16'h0BBB, 0, 0);

      // grpDone during FILL
      step(0, 16'h0000, 1, 0);
      check("underrunSet", 32'(underrun), 32'd1);

      // Hunt and resync
      step(0, 16'h0000, 0, 1);
      step(1, 16'h0123, 0, 0);
      step(1, 16'h0456, 0, 0);
      step(1, 16'h8111, 0, 0);
      step(1, 16'h0222, 0, 0);
      step(1, 16'h8333, 0, 0);
      check("resyncAddr", 32'(wrAddr), 32'd0);
      for (int i = 1; i < G; i++) step(1, 16'(16'h0100 + i), 0, 0);
      check("fullAfterResync", 32'(bufFull), 32'd1);
      step(0, 16'h0000, 0, 0);

      // Simultaneous grpDone and start-of-group word while full
      step(1, 16'h8ABC, 1, 0);
      check("simulAddr", 32'(wrAddr), 32'd0);
      check("simulData", 32'(wrData), 32'h0ABC);
      check("simulOverrun", 32'(overrun), 32'd0);

      // Reset mid-fill cancels the pending write
      step(0, 16'h0000, 0, 1);
      step(1, 16'h8001, 0, 0);
      step(1, 16'h0002, 0, 0);
      step(1, 16'h0003, 0, 0);
      step(1, 16'h0004, 0, 1);
      check("resetNoEn", 32'({wrEn0, wrEn1}), 32'd0);
      step(1, 16'h8005, 0, 0);
      check("afterResetM1", 32'(wrEn1), 32'd1);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         logic        r, gd, rs;
         logic [15:0] w;
         r  = ($urandom_range(0, 9) < 7);
         w  = 16'($urandom);
         w[15] = ($urandom_range(0, 9) == 0);
         gd = ($urandom_range(0, 11) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(r, w, gd, rs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
      $finish;
   end

endmodule
